// File: rtl/teller_sched.sv
// Teller call sequencer: synchronizes desk buttons and the front photocell,
// picks the next desk round-robin, and tracks one call until served, no-show or abort.
module teller_sched #(
  parameter int NT      = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 20,
  parameter int TW      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NT-1:0]   next_btn,
  input  logic [NT-1:0]   desk_open,
  input  logic            empty,
  input  logic            frontPC,
  output logic            call_valid,
  output logic [IDW-1:0]  call_id,
  output logic            served,
  output logic            no_show,
  output logic [NT-1:0]   req_pend,
  output logic [1:0]      Tcount
);

  typedef enum logic {IDLE, CALL} state_t;
  state_t state;

  logic [NT-1:0]  btn_s1, btn_s2, btn_s3, btn_rise;
  logic           pc_s1, pc_s2, pc_s3, pc_fall;
  logic [NT-1:0]  cand, serve_mask;
  logic [IDW-1:0] ptr, winner, id_inc;
  logic [TW-1:0]  timer;
  logic           serve_now, found;
  logic [IDW:0]   idx;
  logic [3:0]     cnt;
  logic [1:0]     tc_next;

  // Third stage only holds the previous synced level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_s3 <= '0;
      pc_s1  <= 1'b1;
      pc_s2  <= 1'b1;
      pc_s3  <= 1'b1;
    end else begin
      btn_s1 <= next_btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      pc_s1  <= frontPC;
      pc_s2  <= pc_s1;
      pc_s3  <= pc_s2;
    end
  end

  assign btn_rise   = btn_s2 & ~btn_s3;
  assign pc_fall    = pc_s3 & ~pc_s2;
  assign cand       = req_pend & desk_open;
  assign id_inc     = (call_id == IDW'(NT-1)) ? '0 : call_id + IDW'(1);
  assign serve_now  = (state == CALL) && desk_open[call_id] && pc_fall;
  assign serve_mask = serve_now ? (NT'(1) << call_id) : '0;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NT; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NT)) idx = idx - (IDW+1)'(NT);
      if (!found && cand[idx[IDW-1:0]]) begin
        winner = idx[IDW-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NT; i++) cnt = cnt + 4'(desk_open[i]);
    if (cnt == 4'd0)      tc_next = 2'd0;
    else if (cnt >= 4'd5) tc_next = 2'd3;
    else                  tc_next = 2'(cnt - 4'd1);
  end

  // A new press beats a same-cycle serve; closing the desk beats everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) req_pend <= '0;
    else      req_pend <= ((req_pend & ~serve_mask) | btn_rise) & desk_open;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      call_valid <= 1'b0;
      call_id    <= '0;
      served     <= 1'b0;
      no_show    <= 1'b0;
      ptr        <= '0;
      timer      <= '0;
      Tcount     <= 2'd0;
    end else begin
      served  <= 1'b0;
      no_show <= 1'b0;
      Tcount  <= tc_next;
      case (state)
        IDLE: begin
          if ((|cand) && !empty) begin
            state      <= CALL;
            call_valid <= 1'b1;
            call_id    <= winner;
            timer      <= '0;
          end
        end
        CALL: begin
          if (!desk_open[call_id] || pc_fall || timer == TW'(TIMEOUT-1)) begin
            state      <= IDLE;
            call_valid <= 1'b0;
            ptr        <= id_inc;
            if (desk_open[call_id]) begin
              if (pc_fall) served  <= 1'b1;
              else         no_show <= 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_teller_sched.sv
// Bench for teller_sched: event-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_teller_sched;
  localparam int NT = 4, IDW = 2, TIMEOUT = 20, TW = 16;

  logic            clk = 1'b0, rst = 1'b0;
  logic [NT-1:0]   next_btn = '0, desk_open = '0;
  logic            empty = 1'b1, frontPC = 1'b1;
  logic            call_valid, served, no_show;
  logic [IDW-1:0]  call_id;
  logic [NT-1:0]   req_pend;
  logic [1:0]      Tcount;

  teller_sched #(.NT(NT), .IDW(IDW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst(rst), .next_btn(next_btn), .desk_open(desk_open),
    .empty(empty), .frontPC(frontPC), .call_valid(call_valid), .call_id(call_id),
    .served(served), .no_show(no_show), .req_pend(req_pend), .Tcount(Tcount));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: input history for the 2-cycle sync delay, call tracked by start cycle.
  bit          m_call, m_served, m_noshow;
  int          m_id, m_ptr, m_start, m_cyc, m_tc;
  bit [NT-1:0] m_req;
  bit [NT-1:0] bh [3];
  bit          ph [3];

  always @(posedge clk or negedge rst) begin
    bit [NT-1:0] rise, cand;
    bit pcf, hit;
    int cnt;
    if (!rst) begin
      m_call = 0; m_served = 0; m_noshow = 0; m_id = 0; m_ptr = 0;
      m_start = 0; m_cyc = 0; m_tc = 0; m_req = '0;
      for (int j = 0; j < 3; j++) begin bh[j] = '0; ph[j] = 1'b1; end
    end else begin
      rise = bh[1] & ~bh[2];
      pcf  = !ph[1] && ph[2];
      bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = next_btn;
      ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = frontPC;
      m_cyc++;
      m_served = 0; m_noshow = 0;
      cand = m_req & desk_open;
      if (m_call) begin
        if (!desk_open[m_id]) begin
          m_call = 0; m_ptr = (m_id + 1) % NT;
        end else if (pcf) begin
          m_served = 1; m_call = 0; m_ptr = (m_id + 1) % NT;
        end else if (m_cyc - m_start == TIMEOUT) begin
          m_noshow = 1; m_call = 0; m_ptr = (m_id + 1) % NT;
        end
      end else if (cand != 0 && !empty) begin
        hit = 0;
        for (int k = 0; k < NT; k++)
          if (!hit && cand[(m_ptr + k) % NT]) begin m_id = (m_ptr + k) % NT; hit = 1; end
        m_call = 1; m_start = m_cyc;
      end
      for (int i = 0; i < NT; i++) begin
        if (!desk_open[i])              m_req[i] = 0;
        else if (rise[i])               m_req[i] = 1;
        else if (m_served && i == m_id) m_req[i] = 0;
      end
      cnt  = $countones(desk_open);
      m_tc = (cnt == 0) ? 0 : ((cnt - 1 > 3) ? 3 : cnt - 1);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("call_valid", int'(call_valid), int'(m_call));
      if (m_call) chk("call_id", int'(call_id), m_id);
      chk("served", int'(served), int'(m_served));
      chk("no_show", int'(no_show), int'(m_noshow));
      chk("req_pend", int'(req_pend), int'(m_req));
      chk("Tcount", int'(Tcount), m_tc);
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  int pc_cnt = 0;

  initial begin
    repeat (3) tick;
    chk("rst_call_valid", int'(call_valid), 0);
    chk("rst_req_pend", int'(req_pend), 0);
    chk("rst_tcount", int'(Tcount), 0);
    rst = 1'b1; tick;

    // Two desks press together: lower index from pointer 0 goes first.
    desk_open = 4'b1111; empty = 1'b0; tick;
    next_btn = 4'b0101; repeat (4) tick;
    chk("b_call_valid", int'(call_valid), 1);
    chk("b_first_id", int'(call_id), 0);
    next_btn = 4'b0000;
    frontPC = 1'b0; repeat (2) tick; frontPC = 1'b1; tick;
    chk("b_served", int'(served), 1);
    chk("b_req_after_serve", int'(req_pend), 4'b0100);
    tick;
    chk("b_second_valid", int'(call_valid), 1);
    chk("b_second_id", int'(call_id), 2);
    frontPC = 1'b0; tick; frontPC = 1'b1; repeat (2) tick;
    chk("b_second_served", int'(served), 1);

    desk_open = 4'b0011; tick; chk("c_tcount_2open", int'(Tcount), 1);
    desk_open = 4'b1111; tick; chk("c_tcount_4open", int'(Tcount), 3);
    desk_open = 4'b0000; tick; chk("c_tcount_closed", int'(Tcount), 0);

    // No-show on desk 1 while desk 3 queues behind it.
    desk_open = 4'b1111; tick;
    next_btn = 4'b0010; repeat (4) tick;
    chk("d_call_id", int'(call_id), 1);
    next_btn = 4'b1010; repeat (TIMEOUT-1) tick;
    chk("d_no_show_early", int'(no_show), 0);
    chk("d_still_calling", int'(call_valid), 1);
    tick;
    chk("d_no_show", int'(no_show), 1);
    chk("d_req1_kept", int'(req_pend[1]), 1);
    tick;
    chk("d_next_id", int'(call_id), 3);

    desk_open = 4'b0111; tick;
    chk("f_abort_valid", int'(call_valid), 0);
    chk("f_abort_req3", int'(req_pend[3]), 0);
    chk("f_abort_served", int'(served), 0);
    chk("f_abort_no_show", int'(no_show), 0);

    next_btn = 4'b0000; desk_open = 4'b0000; tick;
    desk_open = 4'b1111; empty = 1'b1; next_btn = 4'b0100; repeat (6) tick;
    chk("e_empty_hold", int'(call_valid), 0);
    chk("e_req", int'(req_pend), 4'b0100);
    empty = 1'b0; tick;
    chk("e_call_valid", int'(call_valid), 1);
    chk("e_call_id", int'(call_id), 2);

    // Photocell fall lands on the same edge as the timeout.
    repeat (TIMEOUT-3) tick;
    frontPC = 1'b0; tick; frontPC = 1'b1; repeat (2) tick;
    chk("g_served_wins", int'(served), 1);
    chk("g_no_show_low", int'(no_show), 0);
    tick;
    chk("g_no_show_after", int'(no_show), 0);

    next_btn = 4'b0101; repeat (4) tick;
    chk("r_call_up", int'(call_valid), 1);
    chk("r_call_id", int'(call_id), 0);
    next_btn = 4'b0000; rst = 1'b0; #1;
    chk("r_async_valid", int'(call_valid), 0);
    chk("r_async_req", int'(req_pend), 0);
    chk("r_async_tcount", int'(Tcount), 0);
    repeat (3) tick;
    rst = 1'b1; tick;
    chk("r_after_valid", int'(call_valid), 0);
    chk("r_after_req", int'(req_pend), 0);

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NT; i++) begin
        if ($urandom_range(5) == 0)  next_btn[i]  = ~next_btn[i];
        if ($urandom_range(39) == 0) desk_open[i] = ~desk_open[i];
      end
      empty = ($urandom_range(4) == 0);
      if (pc_cnt > 0) begin
        frontPC = 1'b0; pc_cnt--;
      end else begin
        frontPC = 1'b1;
        if ($urandom_range(24) == 0) pc_cnt = $urandom_range(1, 3);
      end
      rst = !(c >= 1500 && c < 1502);
      tick;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/teller_sched.md
Name: teller_sched

Overview:
- Sequencing controller in front of the single-bank queue manager: decides which teller serves the customer at the head of the queue.
- Collects "next customer" requests from up to NT teller desks.
- Arbitrates round-robin and raises a call (teller id on the hall display).
- Closes the call when the customer crosses the front photocell, or abandons it after a no-show timeout.
- Drives Tcount to the queue manager from the number of open desks.

Parameters:
- NT, 4: number of teller desks (2..4).
- IDW, 2: width of call_id; NT <= 2**IDW.
- TIMEOUT, 20: cycles a call may wait for the front photocell before it is declared a no-show (>= 4).
- TW, 16: width of the timeout counter; 2**TW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- next_btn  in  NT  per-desk "next customer" button, level, asynchronous.
- desk_open  in  NT  per-desk on-duty flag, synchronous level.
- empty  in  1  queue-empty flag from queue manager.
- frontPC  in  1  front photocell, active-low, asynchronous; low while a customer passes.
- call_valid  out  1  a call is on the display.
- call_id  out  IDW  desk being called; valid only with call_valid.
- served  out  1  one-cycle pulse: called customer crossed the photocell.
- no_show  out  1  one-cycle pulse: call timed out.
- req_pend  out  NT  pending request per desk.
- Tcount  out  2  teller count to queue manager.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; call_valid=0, call_id=0, served=0, no_show=0, req_pend=0, Tcount=0.
  - RR pointer=0, timer=0.
  - All synchronizer flops preset to their idle levels: frontPC path=1, next_btn path=0.
- Synchronizers: next_btn[i] and frontPC each pass through 2 flops before use.
  - btn_rise[i] = rising edge of synced next_btn[i].
  - pc_fall = falling edge of synced frontPC.
  - Both are one-cycle pulses; pc_fall is seen 2 clocks after the frontPC fall and acted on at the 3rd edge.
- Request latch req_pend[i]:
  - Set on btn_rise[i] while desk_open[i]=1; btn_rise on a closed desk is ignored.
  - Cleared when desk i is served or when desk_open[i]=0.
  - Set and clear in the same cycle: set wins, except on desk close, where clear wins.
- Arbitration, round-robin:
  - Search starts at the pointer and the lowest index at or after it wins, wrapping modulo NT.
  - After any call ends (served, no-show or abort), pointer = call_id+1 mod NT.
- FSM:
  - IDLE: if (req_pend & desk_open) != 0 and empty=0, the next edge enters CALL with call_valid=1, call_id=winner, timer=0. Otherwise stay in IDLE.
  - CALL, evaluated in this priority order each cycle:
    1. desk_open[call_id]=0: abort to IDLE, call_valid=0; no served/no_show pulse.
    2. pc_fall=1: served=1 for one cycle, req_pend[call_id] cleared, state IDLE, call_valid=0.
    3. timer==TIMEOUT-1: no_show=1 for one cycle, req_pend[call_id] retained, state IDLE, call_valid=0.
    4. Otherwise timer++.
  - empty is ignored in CALL. pc_fall in IDLE is ignored.
  - Minimum IDLE dwell between calls is 1 cycle.
- Tcount:
  - Registered each cycle = popcount(desk_open)-1, clamped to 0..3.
  - All desks closed gives Tcount=0.
- Only one call is outstanding at a time; call_id stays stable for the whole CALL state.

Test Plan:
- Reset mid-CALL: rst=0 for 3 cycles while call_valid=1 -> all outputs 0 immediately (asynchronous); after release, state is IDLE and req_pend=0.
- desk_open=4'b1111, empty=0, btn on desks 2 and 0 in the same cycle, pointer=0 -> desk 0 is called first. frontPC low for 2 cycles -> served pulse, then desk 2 is called; pointer ends at 3.
- desk_open=4'b0011, Tcount check -> Tcount=1. Open all 4 desks -> Tcount=3. Close all -> Tcount=0.
- Call desk 1 and hold frontPC high -> no_show pulse exactly TIMEOUT cycles after call_valid rises; req_pend[1] stays 1; desk 1 is re-called only after other pending desks are called.
- empty=1 with req_pend=4'b0100 -> no call. empty falls -> call_valid=1 with call_id=2 one edge later.
- During a call to desk 3, drop desk_open[3] -> call_valid=0 next edge, req_pend[3]=0, no served or no_show pulse. Simultaneous pc_fall and timeout expiry -> served wins, no_show stays 0.
